// File: rtl/core_pkg.sv
// Types and constants shared by the instruction fetch logic.
package core_pkg;

    localparam int          XLEN_DEFAULT = 64;
    localparam int          INSN_BYTES   = 4;
    localparam logic [31:0] NOP_INSN     = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// presents each returned instruction to decode; redirects squash stale data.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_insn_q, if_insn_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            redirect_misaligned;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_insn_q  <= 32'h0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_insn_q  <= if_insn_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_insn_d  = if_insn_q;
        if_pc_d    = if_pc_q;
        // A redirect wins over every other event; once faulted only reset helps.
        if (redirect_valid && state_q != FAULT) begin
            if_valid_d = 1'b0;
            if (redirect_misaligned) begin
                state_d = FAULT;
            end else begin
                pc_d = redirect_pc;
                case (state_q)
                    WAIT, DRAIN: state_d = imem_rsp_valid ? FETCH : DRAIN;
                    default:     state_d = FETCH;
                endcase
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if_insn_d  = imem_rsp_data;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + XLEN'(INSN_BYTES);
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_d = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (state_q == FETCH) && !redirect_valid;
        imem_req_addr  = pc_q;
        fetch_fault    = (state_q == FAULT);
        if_valid       = if_valid_q;
        if_instruction = if_insn_q;
        if_pc          = if_pc_q;
    end

    // Memory may only answer while a request is outstanding.
    a_rsp_protocol: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding-request memory model
// and request/instruction scoreboards.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        fetch_fault;

    fetch_unit #(
        .XLEN     (64),
        .RESET_PC (64'h1000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] req_q[$];
    logic [63:0] exp_q[$];
    logic        mem_pending = 1'b0;
    logic [63:0] mem_addr = 64'h0;
    int          mem_cnt = 0;
    int          mem_delay = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h1000) return 32'h0050_0093;
        return 32'h1357_0000 ^ a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance the memory model.
    task automatic step();
        logic        acc, rspv, fire;
        logic [63:0] a, e;
        imem_req_ready = (req_q.size() != 0);
        #3;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        rspv = imem_rsp_valid;
        fire = if_valid && if_ready && !redirect_valid;
        if (acc && !reset) begin
            e = req_q.pop_front();
            chk("req_addr", a, e);
            $display("req  addr=%h", a);
        end
        if (fire && !reset) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_insn_pc", if_pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                chk("if_pc", if_pc, e);
                chk("if_insn", {32'h0, if_instruction}, {32'h0, mem_word(e)});
                $display("insn pc=%h data=%h", if_pc, if_instruction);
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            mem_pending    = 1'b0;
            imem_rsp_valid = 1'b0;
        end else begin
            if (rspv) begin
                imem_rsp_valid = 1'b0;
                mem_pending    = 1'b0;
            end
            if (acc) begin
                mem_pending = 1'b1;
                mem_addr    = a;
                mem_cnt     = mem_delay;
            end
            if (mem_pending && !imem_rsp_valid) begin
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                end else begin
                    mem_cnt--;
                end
            end
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("run_pending_req", 64'(req_q.size()), 64'h0);
        chk("run_pending_insn", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic wait_accept(input int budget);
        int n = 0;
        while (req_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("accept_timeout", 64'(req_q.size()), 64'h0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!if_valid && n < budget) begin
            step();
            n++;
        end
        chk("valid_timeout", {63'h0, if_valid}, 64'h1);
    endtask

    task automatic pulse_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        step();
        chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_if_insn", {32'h0, if_instruction}, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);
        chk("rst_fault", {63'h0, fetch_fault}, 64'h0);
        reset = 1'b0;
        chk("first_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("first_req_addr", imem_req_addr, 64'h1000);

        // Sequential fetch with a 1-cycle memory.
        req_q = '{64'h1000, 64'h1004, 64'h1008};
        exp_q = '{64'h1000, 64'h1004, 64'h1008};
        run(40);

        // Decode stalls for 5 cycles: outputs hold, no new request.
        req_q = '{64'h100C, 64'h1010};
        exp_q = '{64'h100C, 64'h1010};
        if_ready = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {63'h0, if_valid}, 64'h1);
            chk("hold_pc", if_pc, 64'h100C);
            chk("hold_insn", {32'h0, if_instruction}, {32'h0, mem_word(64'h100C)});
            chk("hold_noreq", {63'h0, imem_req_valid}, 64'h0);
        end
        if_ready = 1'b1;
        run(40);

        // Redirect while waiting on a slow response: that response is dropped.
        mem_delay = 2;
        req_q = '{64'h1014};
        wait_accept(20);
        pulse_redirect(64'h2000);
        mem_delay = 0;
        req_q = '{64'h2000};
        exp_q = '{64'h2000};
        run(40);

        // Redirect in the same cycle as the response.
        req_q = '{64'h2004};
        wait_accept(20);
        chk("rsp_same_cycle", {63'h0, imem_rsp_valid}, 64'h1);
        pulse_redirect(64'h3000);
        req_q = '{64'h3000};
        exp_q = '{64'h3000};
        run(40);

        // Redirect while decode accepts in HOLD: instruction is squashed.
        req_q = '{64'h3004};
        wait_valid(20);
        pulse_redirect(64'h4000);
        chk("squash_valid", {63'h0, if_valid}, 64'h0);
        req_q = '{64'h4000};
        exp_q = '{64'h4000};
        run(40);

        // PC wrap at the top of the address space.
        pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        req_q = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        exp_q = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        run(40);
        chk("wrap_no_fault", {63'h0, fetch_fault}, 64'h0);

        // Misaligned redirect faults; further redirects are ignored.
        pulse_redirect(64'h2002);
        chk("fault_set", {63'h0, fetch_fault}, 64'h1);
        chk("fault_noreq", {63'h0, imem_req_valid}, 64'h0);
        chk("fault_if_valid", {63'h0, if_valid}, 64'h0);
        req_q = '{64'h5000};
        pulse_redirect(64'h5000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_sticky", {63'h0, fetch_fault}, 64'h1);
            chk("fault_still_noreq", {63'h0, imem_req_valid}, 64'h0);
        end
        req_q.delete();
        exp_q.delete();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("fault_cleared", {63'h0, fetch_fault}, 64'h0);
        chk("restart_req", {63'h0, imem_req_valid}, 64'h1);
        chk("restart_addr", imem_req_addr, 64'h1000);
        req_q = '{64'h1000};
        exp_q = '{64'h1000};
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
